// File: rtl/mvm_pkg.sv
// Shared types and FSM encodings for the MVM tile scheduler.
package mvm_pkg;

    localparam int unsigned LANES     = 4;
    localparam int unsigned ACT_W     = 16;
    localparam int unsigned RES_W     = 32;
    localparam int unsigned ACC_W_DEF = 40;

    typedef logic signed [ACT_W-1:0]     act_t;
    typedef logic signed [RES_W-1:0]     res_t;
    typedef logic signed [ACC_W_DEF-1:0] acc_t;

    typedef act_t [LANES-1:0]            act_vec_t;
    typedef act_t [LANES-1:0][LANES-1:0] wgt_tile_t;   // [row i][col j]
    typedef res_t [LANES-1:0]            res_vec_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_OUT   = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    typedef enum logic [2:0] {
        SCHED_IDLE  = ST_IDLE,
        SCHED_ISSUE = ST_ISSUE,
        SCHED_DRAIN = ST_DRAIN,
        SCHED_OUT   = ST_OUT,
        SCHED_FIN   = ST_FIN
    } sched_state_e;

endpackage

// File: rtl/mvm_pipe_tracker.sv
// Tag shift register following issued tiles through SRAM read + MVM latency.
module mvm_pipe_tracker #(
    parameter int unsigned DEPTH = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic in_first,
    output logic res_valid,
    output logic res_first,
    output logic empty
);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] fst_q, fst_d;

    always_comb begin
        vld_d = {vld_q[DEPTH-2:0], in_valid};
        fst_d = {fst_q[DEPTH-2:0], in_valid & in_first};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_q <= '0;
            fst_q <= '0;
        end else begin
            vld_q <= vld_d;
            fst_q <= fst_d;
        end
    end

    assign res_valid = vld_q[DEPTH-1];
    assign res_first = fst_q[DEPTH-1];
    assign empty     = ~|vld_q;

endmodule

// File: rtl/mvm_tile_scheduler.sv
// Tile sequencer for the 4x4x16 MVM unit: reads act/weight tiles, accumulates per row group,
// emits one 4-lane result per group. Define MVM_RELU_EN to clamp negative output lanes to zero.
module mvm_tile_scheduler
    import mvm_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned ACC_W   = 40,
    parameter int unsigned IPU_LAT = 2,
    parameter int unsigned ADDR_W  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [CNT_W-1:0]            cmd_rows,
    input  logic [CNT_W-1:0]            cmd_cols,
    output logic                        act_rd_en,
    output logic [ADDR_W-1:0]           act_rd_addr,
    input  act_vec_t                    act_rd_data,
    output logic                        wgt_rd_en,
    output logic [ADDR_W-1:0]           wgt_rd_addr,
    input  wgt_tile_t                   wgt_rd_data,
    output logic                        mvm_en,
    output act_vec_t                    mvm_act,
    output wgt_tile_t                   mvm_wgt,
    input  res_vec_t                    mvm_res,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES-1:0][ACC_W-1:0] out_data,
    output logic [CNT_W-1:0]            out_grp,
    output logic                        done
);

    sched_state_e                state_q, state_d;
    logic [CNT_W-1:0]            r_q, r_d, c_q, c_d, g_q, g_d, t_q, t_d;
    logic [ADDR_W-1:0]           waddr_q, waddr_d;
    logic                        mvm_en_q, mvm_en_d;
    logic [LANES-1:0][ACC_W-1:0] acc_q, acc_d;
    logic                        issue, issue_first;
    logic                        res_valid, res_first, trk_empty;

    assign issue       = (state_q == SCHED_ISSUE);
    assign issue_first = issue && (t_q == '0);

    // Tags are launched with the read; SRAM (1) + MVM (IPU_LAT) stages later they meet mvm_res.
    mvm_pipe_tracker #(
        .DEPTH (IPU_LAT + 1)
    ) u_tracker (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (issue),
        .in_first  (issue_first),
        .res_valid (res_valid),
        .res_first (res_first),
        .empty     (trk_empty)
    );

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        g_d     = g_q;
        t_d     = t_q;
        waddr_d = waddr_q;
        case (state_q)
            SCHED_IDLE: begin
                if (cmd_valid) begin
                    r_d     = cmd_rows;
                    c_d     = cmd_cols;
                    g_d     = '0;
                    t_d     = '0;
                    waddr_d = '0;
                    state_d = (cmd_rows == '0 || cmd_cols == '0) ? SCHED_FIN : SCHED_ISSUE;
                end
            end
            SCHED_ISSUE: begin
                // Weight address runs linearly across groups, giving g*C + t without a multiplier.
                waddr_d = waddr_q + 1'b1;
                if (t_q == c_q - 1'b1) begin
                    state_d = SCHED_DRAIN;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            SCHED_DRAIN: begin
                if (trk_empty) begin
                    state_d = SCHED_OUT;
                end
            end
            SCHED_OUT: begin
                if (out_ready) begin
                    if (g_q == r_q - 1'b1) begin
                        state_d = SCHED_FIN;
                    end else begin
                        g_d     = g_q + 1'b1;
                        t_d     = '0;
                        state_d = SCHED_ISSUE;
                    end
                end
            end
            SCHED_FIN: begin
                state_d = SCHED_IDLE;
            end
            default: begin
                state_d = SCHED_IDLE;
            end
        endcase
    end

    always_comb begin
        mvm_en_d = issue;
        acc_d    = acc_q;
        if (res_valid) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (res_first) begin
                    acc_d[i] = ACC_W'($signed(mvm_res[i]));
                end else begin
                    acc_d[i] = acc_q[i] + ACC_W'($signed(mvm_res[i]));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= SCHED_IDLE;
            r_q      <= '0;
            c_q      <= '0;
            g_q      <= '0;
            t_q      <= '0;
            waddr_q  <= '0;
            mvm_en_q <= 1'b0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            c_q      <= c_d;
            g_q      <= g_d;
            t_q      <= t_d;
            waddr_q  <= waddr_d;
            mvm_en_q <= mvm_en_d;
            acc_q    <= acc_d;
        end
    end

    assign cmd_ready   = (state_q == SCHED_IDLE);
    assign act_rd_en   = issue;
    assign wgt_rd_en   = issue;
    assign act_rd_addr = ADDR_W'(t_q);
    assign wgt_rd_addr = waddr_q;
    assign mvm_en      = mvm_en_q;
    assign mvm_act     = mvm_en_q ? act_rd_data : '0;
    assign mvm_wgt     = mvm_en_q ? wgt_rd_data : '0;
    assign out_valid   = (state_q == SCHED_OUT);
    assign out_grp     = g_q;
    assign done        = (state_q == SCHED_FIN);

    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
`ifdef MVM_RELU_EN
            out_data[i] = acc_q[i][ACC_W-1] ? '0 : acc_q[i];
`else
            out_data[i] = acc_q[i];
`endif
        end
    end

endmodule
